// File: rtl/ble_uart_pkg.sv
// ble_uart_pkg: shared types and constant helpers for the BLE UART engine.
//   uart_state_t / ST_* : TX and RX frame state encodings (IDLE/START/DATA/STOP)
//   clog2()             : pointer/counter width helper
//   calc_div()          : clock cycles per bit (DIV)
//   calc_half_div()     : cycles to the middle of a bit (HALF_DIV)
package ble_uart_pkg;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      for (v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int calc_half_div(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/ble_uart_fifo.sv
// ble_uart_fifo: synchronous byte FIFO with registered empty/full flags.
//   clk, rst (sync, active-low), flush (sync clear to empty)
//   push/din  : enqueue when not full (push while full is dropped)
//   pop/dout  : dout always shows the head; pop advances when not empty
//   empty/full: registered, updated on the same edge as the pointers
module ble_uart_fifo
   import ble_uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW:0]      wr_ptr_r;
   logic [PW:0]      rd_ptr_r;
   logic [PW:0]      wr_ptr_s;
   logic [PW:0]      rd_ptr_s;
   logic             empty_r;
   logic             full_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests with the current flags and form the next pointers.
   always_comb begin
      do_push_s = push & ~full_r;
      do_pop_s  = pop & ~empty_r;
      wr_ptr_s  = wr_ptr_r + {{PW{1'b0}}, do_push_s};
      rd_ptr_s  = rd_ptr_r + {{PW{1'b0}}, do_pop_s};
   end

   // Pointers and flags; the extra pointer MSB separates full from empty.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
         empty_r  <= (wr_ptr_s == rd_ptr_s);
         full_r   <= (wr_ptr_s[PW] != rd_ptr_s[PW]) &&
                     (wr_ptr_s[PW-1:0] == rd_ptr_s[PW-1:0]);
      end
   end

   // Storage array; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[PW-1:0]] <= din;
      end
   end

   assign dout  = mem_r[rd_ptr_r[PW-1:0]];
   assign empty = empty_r;
   assign full  = full_r;

endmodule

// File: rtl/ble_uart_core.sv
// ble_uart_core: 8N1 UART engine between the BLE Avalon bridge and the radio.
//   clk, rst (sync, active-low)
//   read/read_data/read_empty   : RX FIFO pop side (read_data registered)
//   write/write_data/write_full : TX FIFO push side
//   irq    : 1-cycle pulse per byte stored in the RX FIFO
//   error  : sticky RX overrun / framing error / read-while-empty
//   uart_enable/uart_status     : run control and registered link status
//   ble_state, uart_rxd, uart_txd : radio pins (inputs asynchronous)
// Optional build macro BLE_UART_LOOPBACK_EN: RX listens to the internal TX line
// and the uart_txd pin is held at 1.
module ble_uart_core
   import ble_uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       read,
   output logic [7:0] read_data,
   output logic       read_empty,
   input  logic       write,
   input  logic [7:0] write_data,
   output logic       write_full,
   output logic       irq,
   output logic       error,
   input  logic       uart_enable,
   output logic       uart_status,
   input  logic       ble_state,
   input  logic       uart_rxd,
   output logic       uart_txd
);

   localparam int DIV      = calc_div(CLK_HZ, BAUD);
   localparam int HALF_DIV = calc_half_div(DIV);
   localparam int CW       = clog2(DIV + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV - 1);

   logic          rxd_meta_r, rxd_sync_r, rxd_prev_r;
   logic          state_meta_r, state_sync_r;
   logic          rx_src_s, rx_fall_s;
   logic          txd_r;
   uart_state_t   tx_state_r, rx_state_r;
   logic [CW-1:0] tx_cnt_r, rx_cnt_r;
   logic [2:0]    tx_bit_r, rx_bit_r;
   logic [7:0]    tx_shift_r, rx_shift_r;
   logic [7:0]    tx_dout_s, rx_dout_s;
   logic          tx_empty_s, rx_empty_s, rx_full_s;
   logic          tx_pop_s, rx_stop_s, rx_push_s, err_set_s;
   logic [7:0]    read_data_r;
   logic          irq_r, error_r, status_r;

`ifdef BLE_UART_LOOPBACK_EN
   assign rx_src_s = txd_r;
   assign uart_txd = 1'b1;
`else
   assign rx_src_s = uart_rxd;
   assign uart_txd = txd_r;
`endif

   ble_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (~uart_enable),
      .push  (write & uart_enable),
      .pop   (tx_pop_s),
      .din   (write_data),
      .dout  (tx_dout_s),
      .empty (tx_empty_s),
      .full  (write_full)
   );

   ble_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (~uart_enable),
      .push  (rx_push_s),
      .pop   (read & uart_enable),
      .din   (rx_shift_r),
      .dout  (rx_dout_s),
      .empty (rx_empty_s),
      .full  (rx_full_s)
   );

   // Two-flop synchronisers; rxd_prev_r gives one more stage for edge detect.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rxd_meta_r   <= 1'b1;
         rxd_sync_r   <= 1'b1;
         rxd_prev_r   <= 1'b1;
         state_meta_r <= 1'b0;
         state_sync_r <= 1'b0;
      end else begin
         rxd_meta_r   <= rx_src_s;
         rxd_sync_r   <= rxd_meta_r;
         rxd_prev_r   <= rxd_sync_r;
         state_meta_r <= ble_state;
         state_sync_r <= state_meta_r;
      end
   end

   // TX pops when idle or at the last stop cycle, so queued frames abut.
   always_comb begin
      tx_pop_s = 1'b0;
      if (uart_enable && !tx_empty_s) begin
         if (tx_state_r == ST_IDLE) begin
            tx_pop_s = 1'b1;
         end else if (tx_state_r == ST_STOP && tx_cnt_r == CNT_LAST) begin
            tx_pop_s = 1'b1;
         end else begin
            tx_pop_s = 1'b0;
         end
      end else begin
         tx_pop_s = 1'b0;
      end
   end

   // TX frame sequencer; txd_r is registered and changes on bit boundaries.
   always_ff @(posedge clk) begin
      if (!rst || !uart_enable) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= CNT_ZERO;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         txd_r      <= 1'b1;
      end else begin
         case (tx_state_r)
            ST_IDLE: begin
               if (tx_pop_s) begin
                  tx_shift_r <= tx_dout_s;
                  tx_cnt_r   <= CNT_ZERO;
                  tx_state_r <= ST_START;
                  txd_r      <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_cnt_r == CNT_LAST) begin
                  tx_cnt_r   <= CNT_ZERO;
                  tx_bit_r   <= 3'd0;
                  txd_r      <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  tx_state_r <= ST_DATA;
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (tx_cnt_r == CNT_LAST) begin
                  tx_cnt_r <= CNT_ZERO;
                  if (tx_bit_r == 3'd7) begin
                     txd_r      <= 1'b1;
                     tx_state_r <= ST_STOP;
                  end else begin
                     txd_r      <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     tx_bit_r   <= tx_bit_r + 3'd1;
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (tx_cnt_r == CNT_LAST) begin
                  tx_cnt_r <= CNT_ZERO;
                  if (tx_pop_s) begin
                     tx_shift_r <= tx_dout_s;
                     tx_state_r <= ST_START;
                     txd_r      <= 1'b0;
                  end else begin
                     tx_state_r <= ST_IDLE;
                     txd_r      <= 1'b1;
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + CNT_ONE;
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               tx_cnt_r   <= CNT_ZERO;
               txd_r      <= 1'b1;
            end
         endcase
      end
   end

   // RX stop-bit decision: good stop pushes unless the FIFO is full.
   always_comb begin
      rx_fall_s = rxd_prev_r & ~rxd_sync_r;
      rx_stop_s = uart_enable & (rx_state_r == ST_STOP) & (rx_cnt_r == CNT_LAST);
      rx_push_s = rx_stop_s & rxd_sync_r & ~rx_full_s;
      err_set_s = (rx_stop_s & ~rxd_sync_r) |
                  (rx_stop_s & rxd_sync_r & rx_full_s) |
                  (uart_enable & read & rx_empty_s);
   end

   // RX frame sequencer: half-bit start check, then one sample per bit.
   always_ff @(posedge clk) begin
      if (!rst || !uart_enable) begin
         rx_state_r <= ST_IDLE;
         rx_cnt_r   <= CNT_ZERO;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
      end else begin
         case (rx_state_r)
            ST_IDLE: begin
               if (rx_fall_s) begin
                  rx_cnt_r   <= CNT_ZERO;
                  rx_state_r <= ST_START;
               end
            end
            ST_START: begin
               if (rx_cnt_r == CNT_HALF) begin
                  rx_cnt_r   <= CNT_ZERO;
                  rx_bit_r   <= 3'd0;
                  rx_state_r <= rxd_sync_r ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (rx_cnt_r == CNT_LAST) begin
                  rx_cnt_r   <= CNT_ZERO;
                  rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) begin
                     rx_state_r <= ST_STOP;
                  end else begin
                     rx_bit_r <= rx_bit_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (rx_cnt_r == CNT_LAST) begin
                  rx_cnt_r   <= CNT_ZERO;
                  rx_state_r <= ST_IDLE;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            default: begin
               rx_state_r <= ST_IDLE;
               rx_cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   // Bridge-facing registers; read_data survives a disable, the rest clears.
   always_ff @(posedge clk) begin
      if (!rst) begin
         read_data_r <= 8'h00;
         irq_r       <= 1'b0;
         error_r     <= 1'b0;
         status_r    <= 1'b0;
      end else if (!uart_enable) begin
         irq_r    <= 1'b0;
         error_r  <= 1'b0;
         status_r <= 1'b0;
      end else begin
         if (read) begin
            read_data_r <= rx_empty_s ? 8'h00 : rx_dout_s;
         end
         irq_r    <= rx_push_s;
         error_r  <= error_r | err_set_s;
         status_r <= state_sync_r;
      end
   end

   assign read_data   = read_data_r;
   assign read_empty  = rx_empty_s;
   assign irq         = irq_r;
   assign error       = error_r;
   assign uart_status = status_r;

endmodule

// File: tb/tb_ble_uart_core.sv
// Directed bench for ble_uart_core with CLK_HZ=16, BAUD=2 (8 cycles/bit), FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
module tb_ble_uart_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [7:0] write_data = 8'h00;
   logic       uart_enable = 1'b0;
   logic       ble_state = 1'b0;
   logic       uart_rxd = 1'b1;
   logic [7:0] read_data;
   logic       read_empty, write_full, irq, error, uart_status, uart_txd;

   int checks = 0;
   int errors = 0;
   int irq_cnt = 0;

   always #5 clk = ~clk;

   // Count every cycle irq is high so a stretched pulse shows up as extra counts.
   always @(negedge clk) begin
      if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
   end

   ble_uart_core #(.CLK_HZ(16), .BAUD(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .read(read), .read_data(read_data), .read_empty(read_empty),
      .write(write), .write_data(write_data), .write_full(write_full), .irq(irq),
      .error(error), .uart_enable(uart_enable), .uart_status(uart_status),
      .ble_state(ble_state), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
      uart_rxd = 1'b0;
      tick(8);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         tick(8);
      end
      uart_rxd = stop_bit;
      tick(8);
      uart_rxd = 1'b1;
   endtask

   task automatic pop_byte();
      read = 1'b1;
      tick(1);
      read = 1'b0;
   endtask

   task automatic test_reset();
      ble_state = 1'b1;
      uart_enable = 1'b1;
      rst = 1'b0;
      tick(3);
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data got %h exp 00", read_data); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
      checks++; if (uart_status !== 1'b0) begin errors++; $display("FAIL reset_status got %b exp 0", uart_status); end
      checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
      checks++; if (read_empty !== 1'b1) begin errors++; $display("FAIL reset_read_empty got %b exp 1", read_empty); end
      checks++; if (write_full !== 1'b0) begin errors++; $display("FAIL reset_write_full got %b exp 0", write_full); end
      rst = 1'b1;
   endtask

   task automatic test_status();
      tick(4);
      checks++; if (uart_status !== 1'b1) begin errors++; $display("FAIL status_high got %b exp 1", uart_status); end
      ble_state = 1'b0;
      tick(4);
      checks++; if (uart_status !== 1'b0) begin errors++; $display("FAIL status_low got %b exp 0", uart_status); end
   endtask

   task automatic test_tx();
      logic [7:0] b;
      logic [9:0] frame;
      int waited;
      b = 8'hA5;
      frame = {1'b1, b, 1'b0};
      write_data = b;
      write = 1'b1;
      tick(1);
      write = 1'b0;
      waited = 0;
      while (uart_txd !== 1'b0 && waited < 20) begin
         tick(1);
         waited++;
      end
      checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL tx_start_timeout got %b exp 0", uart_txd); end
      if (uart_txd === 1'b0) begin
         tick(7);
         checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL tx_start_len got %b exp 0", uart_txd); end
         tick(1);
         checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_bit0_edge got %b exp 1", uart_txd); end
         tick(4);
         for (int k = 1; k < 10; k++) begin
            checks++;
            if (uart_txd !== frame[k]) begin
               errors++; $display("FAIL tx_bit%0d got %b exp %b", k, uart_txd, frame[k]);
            end
            tick(8);
         end
         checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_idle_after got %b exp 1", uart_txd); end
      end
   endtask

   task automatic test_rx();
      int irq0;
      irq0 = irq_cnt;
      drive_rx_frame(8'h3C, 1'b1);
      tick(2);
      checks++; if (irq_cnt - irq0 !== 1) begin errors++; $display("FAIL rx_irq_count got %0d exp 1", irq_cnt - irq0); end
      checks++; if (read_empty !== 1'b0) begin errors++; $display("FAIL rx_not_empty got %b exp 0", read_empty); end
      pop_byte();
      checks++; if (read_data !== 8'h3C) begin errors++; $display("FAIL rx_data got %h exp 3c", read_data); end
      checks++; if (read_empty !== 1'b1) begin errors++; $display("FAIL rx_empty_after got %b exp 1", read_empty); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rx_no_error got %b exp 0", error); end
   endtask

   task automatic test_overrun();
      logic [7:0] bytes [5];
      int irq0;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
      irq0 = irq_cnt;
      for (int i = 0; i < 5; i++) begin
         drive_rx_frame(bytes[i], 1'b1);
         if (i == 3) begin
            checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovr_error_early got %b exp 0", error); end
         end
      end
      tick(2);
      checks++; if (irq_cnt - irq0 !== 4) begin errors++; $display("FAIL ovr_irq_count got %0d exp 4", irq_cnt - irq0); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovr_error got %b exp 1", error); end
      for (int i = 0; i < 4; i++) begin
         pop_byte();
         checks++;
         if (read_data !== bytes[i]) begin
            errors++; $display("FAIL ovr_pop%0d got %h exp %h", i, read_data, bytes[i]);
         end
      end
      checks++; if (read_empty !== 1'b1) begin errors++; $display("FAIL ovr_empty got %b exp 1", read_empty); end
   endtask

   task automatic test_framing();
      int irq0;
      uart_enable = 1'b0;
      tick(2);
      uart_enable = 1'b1;
      tick(4);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL frm_error_cleared got %b exp 0", error); end
      checks++; if (read_data !== 8'h44) begin errors++; $display("FAIL frm_read_data_hold got %h exp 44", read_data); end
      irq0 = irq_cnt;
      drive_rx_frame(8'h0F, 1'b0);
      tick(2);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL frm_error got %b exp 1", error); end
      checks++; if (irq_cnt - irq0 !== 0) begin errors++; $display("FAIL frm_irq got %0d exp 0", irq_cnt - irq0); end
      checks++; if (read_empty !== 1'b1) begin errors++; $display("FAIL frm_empty got %b exp 1", read_empty); end
      uart_enable = 1'b0;
      tick(1);
      uart_enable = 1'b1;
      tick(1);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL frm_error_reenable got %b exp 0", error); end
      tick(8);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [6];
      logic [9:0] frame;
      bytes[0] = 8'h81; bytes[1] = 8'h42; bytes[2] = 8'hC3;
      bytes[3] = 8'h24; bytes[4] = 8'hE7; bytes[5] = 8'h99;
      write = 1'b1;
      for (int i = 0; i < 6; i++) begin
         write_data = bytes[i];
         tick(1);
         if (i == 3) begin
            checks++; if (write_full !== 1'b0) begin errors++; $display("FAIL b2b_not_full got %b exp 0", write_full); end
         end
      end
      write = 1'b0;
      // First byte went to the shifter on the edge after its write; four are queued.
      checks++; if (write_full !== 1'b1) begin errors++; $display("FAIL b2b_full got %b exp 1", write_full); end
      // Now 4 cycles into the first start bit: sample every bit at its middle.
      for (int f = 0; f < 5; f++) begin
         frame = {1'b1, bytes[f], 1'b0};
         for (int k = 0; k < 10; k++) begin
            if (f != 0 || k != 0) tick(8);
            checks++;
            if (uart_txd !== frame[k]) begin
               errors++; $display("FAIL b2b_f%0d_bit%0d got %b exp %b", f, k, uart_txd, frame[k]);
            end
            if (f == 1 && k == 0) begin
               checks++; if (write_full !== 1'b0) begin errors++; $display("FAIL b2b_full_clear got %b exp 0", write_full); end
            end
         end
      end
      tick(8);
      checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL b2b_dropped_sixth got %b exp 1", uart_txd); end
      tick(8);
   endtask

   task automatic test_reset_mid();
      int waited;
      write = 1'b1;
      write_data = 8'h00;
      tick(1);
      write_data = 8'h11;
      tick(1);
      write = 1'b0;
      waited = 0;
      while (uart_txd !== 1'b0 && waited < 20) begin
         tick(1);
         waited++;
      end
      // Start seen already (queued behind the first write); middle of data bit 0.
      tick(11);
      checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL rstmid_databit got %b exp 0", uart_txd); end
      rst = 1'b0;
      tick(1);
      checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got %b exp 1", uart_txd); end
      checks++; if (read_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", read_empty); end
      checks++; if (write_full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b exp 0", write_full); end
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rstmid_read_data got %h exp 00", read_data); end
      rst = 1'b1;
      tick(20);
      checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rstmid_flushed got %b exp 1", uart_txd); end
      pop_byte();
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rd_empty_data got %h exp 00", read_data); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL rd_empty_error got %b exp 1", error); end
   endtask

   task automatic test_loopback();
      int irq0;
      int waited;
      logic pin_moved;
      irq0 = irq_cnt;
      pin_moved = 1'b0;
      write_data = 8'h5A;
      write = 1'b1;
      tick(1);
      write = 1'b0;
      waited = 0;
      while (irq_cnt == irq0 && waited < 200) begin
         tick(1);
         waited++;
         if (uart_txd !== 1'b1) pin_moved = 1'b1;
      end
      tick(2);
      checks++; if (irq_cnt - irq0 !== 1) begin errors++; $display("FAIL lb_irq got %0d exp 1", irq_cnt - irq0); end
      checks++; if (pin_moved !== 1'b0) begin errors++; $display("FAIL lb_pin_toggled got %b exp 0", pin_moved); end
      pop_byte();
      checks++; if (read_data !== 8'h5A) begin errors++; $display("FAIL lb_data got %h exp 5a", read_data); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL lb_error got %b exp 0", error); end
   endtask

   initial begin
      tick(1);
      test_reset();
`ifdef BLE_UART_LOOPBACK_EN
      tick(4);
      test_loopback();
`else
      test_status();
      test_tx();
      test_rx();
      test_overrun();
      test_framing();
      test_back_to_back();
      test_reset_mid();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
